ts_pkt_arbiter: RTL and testbench
=================================

TS_PKT_ARBITER -- requirements
Module: ts_pkt_arbiter

Interface
REQ-001 Parameter PACKET_LEN, default 188: bytes per TS packet forwarded per grant.
REQ-002 Parameter NUM_PORTS, fixed 4: number of byte-wide TS requester ports.
REQ-003 clk  input  1  single clock for all ports; all logic on posedge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 port_enable  input  4  per-port arbitration enable, static or quasi-static.
REQ-006 in_valid  input  4  per-port byte valid.
REQ-007 in_sync  input  4  per-port packet-start flag, qualified by in_valid.
REQ-008 in_data  input  32  per-port byte; port i on bits [8i+7:8i].
REQ-009 in_ready  output  4  per-port byte accept; a byte transfers on in_valid[i] & in_ready[i].
REQ-010 out_ready  input  1  downstream accept.
REQ-011 mpeg_valid_out  output  1  output byte valid.
REQ-012 mpeg_sync_out  output  1  first byte of forwarded packet.
REQ-013 mpeg_data_out  output  8  output byte.
REQ-014 grant  output  2  index of current/last granted port.
REQ-015 busy  output  1  high in PASS state.
REQ-016 pkt_count  output  32  packets fully forwarded, wrapping.
REQ-017 short_err_count  output  16  packets aborted short, saturating at 0xFFFF.
REQ-018 drop_count  output  16  bytes discarded while hunting sync, saturating at 0xFFFF.

Function
REQ-019 Two states, IDLE and PASS; state, grant, byte_cnt, last_grant and counters are registers.
REQ-020 Request: port i requests when port_enable[i] & in_valid[i] & in_sync[i].
REQ-021 IDLE: if any request, select the first requesting port after last_grant in round-robin order (last_grant+1, +2, +3, +0 mod 4); load grant, clear byte_cnt, enter PASS next cycle; no byte is consumed in the arbitration cycle.
REQ-022 IDLE with no request: remain in IDLE; all in_ready for enabled ports follow REQ-025.
REQ-023 PASS: mpeg_valid_out = in_valid[grant]; mpeg_data_out = in_data[grant]; in_ready[grant] = out_ready; combinational, zero latency.
REQ-024 PASS: mpeg_sync_out = mpeg_valid_out & (byte_cnt == 0).
REQ-025 Hunt discard, any state: for enabled port i not currently granted-in-PASS, in_ready[i] = in_valid[i] & ~in_sync[i]; each such transfer increments drop_count. Sync-flagged heads are held for arbitration.
REQ-026 Disabled ports: in_ready[i] = 0; never granted; data held upstream.
REQ-027 PASS, each transfer: byte_cnt increments; transfer with byte_cnt == PACKET_LEN-1 increments pkt_count, sets last_grant = grant, returns to IDLE.
REQ-028 Short packet: in PASS with byte_cnt != 0 and in_valid[grant] & in_sync[grant]: in_ready[grant] = 0, mpeg_valid_out = 0, byte not consumed; short_err_count increments; last_grant = grant; return to IDLE. The held sync byte re-requests normally.
REQ-029 Sync with byte_cnt == 0 in PASS is the packet's own first byte and is forwarded.
REQ-030 Clearing port_enable[grant] mid-packet does not abort; packet completes, then port is excluded.
REQ-031 out_ready low in PASS: no transfer, byte_cnt and outputs hold; mpeg_valid_out may stay high.
REQ-032 IDLE: mpeg_valid_out = 0, mpeg_sync_out = 0, mpeg_data_out = 0.
REQ-033 byte_cnt width 8 bits; never exceeds PACKET_LEN-1.
REQ-034 Simultaneous drop-count increments from multiple ports in one cycle: add count of discarding ports (0..4), saturating.

Reset
REQ-035 rst_n low asynchronously forces IDLE, grant = 0, last_grant = 3 (port 0 wins first), byte_cnt = 0, all counters 0, in_ready = 0, mpeg_valid_out = 0, mpeg_sync_out = 0, mpeg_data_out = 0, busy = 0.
REQ-036 Reset mid-packet abandons the packet without counting it; after release arbitration restarts from REQ-035 state.
REQ-037 in_ready stays 0 for the first clk edge after rst_n deassertion.

Verification
REQ-038 All 4 ports enabled, each presenting back-to-back 188-byte packets, out_ready=1 -> grants 0,1,2,3,0 in order; each output packet 188 bytes, sync on first only; pkt_count=5 after five packets.
REQ-039 Port 2 presents 5 non-sync bytes then a packet -> drop_count=5, packet forwarded intact with 0x47 first byte.
REQ-040 Port 1 asserts sync at byte 100 of its packet -> short_err_count=1, 100 bytes output, next packet from port 1 forwarded complete after re-arbitration.
REQ-041 out_ready toggled 1/0 every cycle during a packet -> exactly 188 transfers, data order preserved, byte_cnt frozen during stalls.
REQ-042 port_enable=0b0101 with all ports requesting -> only ports 0 and 2 granted alternately; in_ready[1], in_ready[3] remain 0.
REQ-043 rst_n pulsed low at byte 50 -> outputs zero immediately, pkt_count=0, first post-reset grant to lowest-index requesting port.

Source files
------------

// File: rtl/ts_pkt_arbiter.sv
// Round-robin arbiter that forwards whole TS packets from one of four byte-wide
// requester ports onto a single byte stream, discarding bytes until a sync is seen.
//
// state | meaning
// IDLE  | no packet in flight; pick the next sync-flagged port after last_grant
// PASS  | forwarding bytes of the granted port until PACKET_LEN bytes or a short abort
module ts_pkt_arbiter #(
  parameter int PACKET_LEN = 188,
  parameter int NUM_PORTS  = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_PORTS-1:0]   port_enable,
  input  logic [NUM_PORTS-1:0]   in_valid,
  input  logic [NUM_PORTS-1:0]   in_sync,
  input  logic [8*NUM_PORTS-1:0] in_data,
  output logic [NUM_PORTS-1:0]   in_ready,
  input  logic                   out_ready,
  output logic                   mpeg_valid_out,
  output logic                   mpeg_sync_out,
  output logic [7:0]             mpeg_data_out,
  output logic [1:0]             grant,
  output logic                   busy,
  output logic [31:0]            pkt_count,
  output logic [15:0]            short_err_count,
  output logic [15:0]            drop_count
);

  localparam logic [7:0] LAST_BYTE = 8'(PACKET_LEN - 1);

  typedef enum logic {IDLE, PASS} state_t;

  state_t                 state, state_nxt;
  logic [1:0]             grant_nxt;
  logic [1:0]             last_grant, last_grant_nxt;
  logic [7:0]             byte_cnt, byte_cnt_nxt;
  logic                   ready_en;
  logic [NUM_PORTS-1:0]   req;
  logic [NUM_PORTS-1:0]   drop_xfer;
  logic [1:0]             rr_sel;
  logic [1:0]             rr_idx;
  logic                   rr_hit;
  logic                   g_valid;
  logic                   g_sync;
  logic [7:0]             g_data;
  logic                   short_pkt;
  logic                   pkt_done;
  logic [2:0]             drop_num;
  logic [16:0]            drop_sum;

  assign req     = port_enable & in_valid & in_sync;
  assign g_valid = in_valid[grant];
  assign g_sync  = in_sync[grant];
  assign g_data  = in_data[{grant, 3'b000} +: 8];
  assign busy    = (state == PASS);

  // Search order starts just after the last granted port.
  always_comb begin
    rr_sel = last_grant;
    rr_hit = 1'b0;
    rr_idx = last_grant;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      rr_idx = last_grant + 2'(k);
      if (!rr_hit && req[rr_idx]) begin
        rr_sel = rr_idx;
        rr_hit = 1'b1;
      end
    end
  end

  always_comb begin
    state_nxt      = state;
    grant_nxt      = grant;
    last_grant_nxt = last_grant;
    byte_cnt_nxt   = byte_cnt;
    in_ready       = '0;
    drop_xfer      = '0;
    mpeg_valid_out = 1'b0;
    mpeg_sync_out  = 1'b0;
    mpeg_data_out  = 8'h00;
    short_pkt      = 1'b0;
    pkt_done       = 1'b0;

    // Non-sync heads on idle ports are flushed; sync heads wait for arbitration.
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (port_enable[i] && !(state == PASS && grant == 2'(i)))
        drop_xfer[i] = ready_en & in_valid[i] & ~in_sync[i];
    end
    in_ready = drop_xfer;

    case (state)
      IDLE: begin
        if (rr_hit) begin
          grant_nxt    = rr_sel;
          byte_cnt_nxt = 8'd0;
          state_nxt    = PASS;
        end
      end
      PASS: begin
        if (byte_cnt != 8'd0 && g_valid && g_sync) begin
          // A new packet started before this one finished; leave its sync byte queued.
          short_pkt      = 1'b1;
          last_grant_nxt = grant;
          byte_cnt_nxt   = 8'd0;
          state_nxt      = IDLE;
        end else begin
          mpeg_valid_out  = g_valid;
          mpeg_sync_out   = g_valid && (byte_cnt == 8'd0);
          mpeg_data_out   = g_data;
          in_ready[grant] = out_ready & ready_en;
          if (g_valid && out_ready && ready_en) begin
            if (byte_cnt == LAST_BYTE) begin
              pkt_done       = 1'b1;
              last_grant_nxt = grant;
              byte_cnt_nxt   = 8'd0;
              state_nxt      = IDLE;
            end else begin
              byte_cnt_nxt = byte_cnt + 8'd1;
            end
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    drop_num = 3'd0;
    for (int i = 0; i < NUM_PORTS; i++)
      drop_num = drop_num + {2'b00, drop_xfer[i]};
    drop_sum = {1'b0, drop_count} + {14'd0, drop_num};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      grant      <= 2'd0;
      last_grant <= 2'd3;
      byte_cnt   <= 8'd0;
      ready_en   <= 1'b0;
    end else begin
      state      <= state_nxt;
      grant      <= grant_nxt;
      last_grant <= last_grant_nxt;
      byte_cnt   <= byte_cnt_nxt;
      ready_en   <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_count       <= 32'd0;
      short_err_count <= 16'd0;
      drop_count      <= 16'd0;
    end else begin
      if (pkt_done)
        pkt_count <= pkt_count + 32'd1;
      if (short_pkt && short_err_count != 16'hFFFF)
        short_err_count <= short_err_count + 16'd1;
      drop_count <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
  end

endmodule

// File: tb/tb_ts_pkt_arbiter.sv
// Directed bench for ts_pkt_arbiter: per-port byte sources, output capture and
// hand-built expected packet streams.
module tb_ts_pkt_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  port_enable;
  logic [3:0]  in_valid;
  logic [3:0]  in_sync;
  logic [31:0] in_data;
  logic [3:0]  in_ready;
  logic        out_ready;
  logic        mpeg_valid_out;
  logic        mpeg_sync_out;
  logic [7:0]  mpeg_data_out;
  logic [1:0]  grant;
  logic        busy;
  logic [31:0] pkt_count;
  logic [15:0] short_err_count;
  logic [15:0] drop_count;

  ts_pkt_arbiter #(.PACKET_LEN(188), .NUM_PORTS(4)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .port_enable     (port_enable),
    .in_valid        (in_valid),
    .in_sync         (in_sync),
    .in_data         (in_data),
    .in_ready        (in_ready),
    .out_ready       (out_ready),
    .mpeg_valid_out  (mpeg_valid_out),
    .mpeg_sync_out   (mpeg_sync_out),
    .mpeg_data_out   (mpeg_data_out),
    .grant           (grant),
    .busy            (busy),
    .pkt_count       (pkt_count),
    .short_err_count (short_err_count),
    .drop_count      (drop_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [8:0] src_mem [4][1024];
  int         wr_ptr [4];
  int         rd_ptr [4];
  logic [8:0] out_log [2048];
  logic [8:0] exp_log [2048];
  int         out_n, exp_n, n_sync;
  int         sync_grant [16];
  bit         toggle_ready;
  bit         seen_bad_ready;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] pkt_byte(int port, int id, int j);
    if (j == 0) return 8'h47;
    return 8'((port * 61 + id * 13 + j) & 255);
  endfunction

  task automatic add_src(int port, int id, int n);
    for (int j = 0; j < n; j++) begin
      src_mem[port][wr_ptr[port]] = {(j == 0), pkt_byte(port, id, j)};
      wr_ptr[port]++;
    end
  endtask

  task automatic add_exp(int port, int id, int n);
    for (int j = 0; j < n; j++) begin
      exp_log[exp_n] = {(j == 0), pkt_byte(port, id, j)};
      exp_n++;
    end
  endtask

  task automatic drive();
    for (int i = 0; i < 4; i++) begin
      if (rd_ptr[i] < wr_ptr[i]) begin
        in_valid[i]      = 1'b1;
        in_sync[i]       = src_mem[i][rd_ptr[i]][8];
        in_data[8*i +: 8] = src_mem[i][rd_ptr[i]][7:0];
      end else begin
        in_valid[i]      = 1'b0;
        in_sync[i]       = 1'b0;
        in_data[8*i +: 8] = 8'h00;
      end
    end
  endtask

  task automatic clear_all();
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wr_ptr[i] = 0;
      rd_ptr[i] = 0;
    end
    out_n = 0;
    exp_n = 0;
    n_sync = 0;
    toggle_ready = 1'b0;
    seen_bad_ready = 1'b0;
    out_ready = 1'b1;
  endtask

  // Holds reset two edges, then releases just after a rising edge.
  task automatic apply_reset();
    rst_n = 1'b0;
    drive();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  // One clock: observe at the falling edge, advance sources just after the rising edge.
  task automatic step();
    logic [3:0] xfer;
    @(negedge clk);
    xfer = in_valid & in_ready;
    if (mpeg_valid_out && out_ready) begin
      out_log[out_n] = {mpeg_sync_out, mpeg_data_out};
      out_n++;
      if (mpeg_sync_out && n_sync < 16) begin
        sync_grant[n_sync] = int'(grant);
        n_sync++;
      end
    end
    if (in_ready[1] || in_ready[3]) seen_bad_ready = 1'b1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++)
      if (xfer[i]) rd_ptr[i]++;
    if (toggle_ready) out_ready = ~out_ready;
    drive();
  endtask

  task automatic run_until_pkts(int n, int budget);
    int c = 0;
    while (pkt_count < 32'(n) && c < budget) begin
      step();
      c++;
    end
  endtask

  task automatic check_stream(input string tag);
    int e = 0;
    for (int i = 0; i < exp_n; i++)
      if (i >= out_n || out_log[i] !== exp_log[i]) e++;
    chk({tag, "_len"}, out_n, exp_n);
    chk({tag, "_data_errs"}, e, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    port_enable = 4'h0;
    in_valid = 4'h0;
    in_sync = 4'h0;
    in_data = 32'h0;
    clear_all();
    drive();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 4'h0);
    chk("rst_valid", mpeg_valid_out, 1'b0);
    chk("rst_sync", mpeg_sync_out, 1'b0);
    chk("rst_data", mpeg_data_out, 8'h00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_grant", grant, 2'd0);
    chk("rst_pkt", pkt_count, 32'd0);
    chk("rst_short", short_err_count, 16'd0);
    chk("rst_drop", drop_count, 16'd0);

    // All ports, back-to-back packets: round robin 0,1,2,3,0.
    clear_all();
    port_enable = 4'hF;
    for (int p = 0; p < 4; p++) begin
      add_src(p, 0, 188);
      add_src(p, 1, 188);
    end
    add_exp(0, 0, 188);
    add_exp(1, 0, 188);
    add_exp(2, 0, 188);
    add_exp(3, 0, 188);
    add_exp(0, 1, 188);
    apply_reset();
    run_until_pkts(5, 1200);
    chk("rr_pkt_count", pkt_count, 32'd5);
    chk("rr_n_sync", n_sync, 5);
    chk("rr_grant0", sync_grant[0], 0);
    chk("rr_grant1", sync_grant[1], 1);
    chk("rr_grant2", sync_grant[2], 2);
    chk("rr_grant3", sync_grant[3], 3);
    chk("rr_grant4", sync_grant[4], 0);
    check_stream("rr");
    chk("rr_short", short_err_count, 16'd0);
    chk("rr_drop", drop_count, 16'd0);

    // Port 2: five junk bytes before a packet.
    clear_all();
    port_enable = 4'hF;
    for (int j = 0; j < 5; j++) begin
      src_mem[2][wr_ptr[2]] = {1'b0, 8'(8'h10 + j)};
      wr_ptr[2]++;
    end
    add_src(2, 0, 188);
    add_exp(2, 0, 188);
    apply_reset();
    chk("hunt_ready_first_edge", in_ready, 4'h0);
    step();
    chk("hunt_ready_after_edge", in_ready, 4'b0100);
    run_until_pkts(1, 400);
    chk("hunt_pkt_count", pkt_count, 32'd1);
    chk("hunt_drop", drop_count, 16'd5);
    chk("hunt_grant", sync_grant[0], 2);
    chk("hunt_first_byte", out_log[0], 9'h147);
    check_stream("hunt");

    // Port 1: sync arrives at byte 100, aborting the first packet.
    clear_all();
    port_enable = 4'hF;
    add_src(1, 0, 100);
    add_src(1, 1, 188);
    add_exp(1, 0, 100);
    add_exp(1, 1, 188);
    apply_reset();
    run_until_pkts(1, 600);
    chk("short_err", short_err_count, 16'd1);
    chk("short_pkt_count", pkt_count, 32'd1);
    chk("short_n_sync", n_sync, 2);
    chk("short_grant0", sync_grant[0], 1);
    chk("short_grant1", sync_grant[1], 1);
    check_stream("short");

    // Downstream backpressure alternating every cycle.
    clear_all();
    port_enable = 4'hF;
    add_src(0, 0, 188);
    add_exp(0, 0, 188);
    toggle_ready = 1'b1;
    apply_reset();
    run_until_pkts(1, 800);
    chk("stall_pkt_count", pkt_count, 32'd1);
    chk("stall_n_sync", n_sync, 1);
    check_stream("stall");

    // Only ports 0 and 2 enabled.
    clear_all();
    port_enable = 4'b0101;
    for (int p = 0; p < 4; p++) begin
      add_src(p, 0, 188);
      add_src(p, 1, 188);
    end
    add_exp(0, 0, 188);
    add_exp(2, 0, 188);
    add_exp(0, 1, 188);
    add_exp(2, 1, 188);
    apply_reset();
    run_until_pkts(4, 1200);
    chk("en_pkt_count", pkt_count, 32'd4);
    chk("en_grant0", sync_grant[0], 0);
    chk("en_grant1", sync_grant[1], 2);
    chk("en_grant2", sync_grant[2], 0);
    chk("en_grant3", sync_grant[3], 2);
    check_stream("en");
    chk("en_disabled_ready", seen_bad_ready, 1'b0);
    chk("en_port1_untouched", rd_ptr[1], 0);
    chk("en_port3_untouched", rd_ptr[3], 0);

    // Reset pulsed after 50 bytes of port 1's packet.
    clear_all();
    port_enable = 4'hF;
    add_src(1, 0, 188);
    add_src(2, 0, 188);
    add_src(3, 0, 188);
    apply_reset();
    begin
      int c = 0;
      while (out_n < 50 && c < 400) begin
        step();
        c++;
      end
    end
    chk("mid_pre_bytes", out_n, 50);
    chk("mid_pre_grant", grant, 2'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", mpeg_valid_out, 1'b0);
    chk("mid_rst_data", mpeg_data_out, 8'h00);
    chk("mid_rst_ready", in_ready, 4'h0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_pkt", pkt_count, 32'd0);
    out_n = 0;
    n_sync = 0;
    exp_n = 0;
    add_exp(2, 0, 188);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_until_pkts(1, 600);
    chk("mid_post_pkt", pkt_count, 32'd1);
    chk("mid_post_grant", sync_grant[0], 2);
    chk("mid_post_n_sync", n_sync, 1);
    check_stream("mid_post");
    chk("mid_post_drop", drop_count, 16'd138);
    chk("mid_post_short", short_err_count, 16'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
